// File: rtl/klein_serial.sv
// klein_serial: byte-serial KLEIN block cipher (64-bit block, 64/80/96-bit key).
// Plaintext and key bytes shift in MSB-first. One full round is computed per
// clock, then the whitened ciphertext is presented one byte per clock.
//
// Handshake: start is looked at only while busy=0. ready marks each of the 8
// ciphertext bytes on out. There is no back-pressure, and out reads 8'h00
// whenever ready is low.
module klein_serial #(
  parameter int KEY_BITS = 80
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       start,
  input  logic [0:7] inp,
  input  logic [0:7] key,
  output logic       busy,
  output logic       ready,
  output logic [0:7] out,
  output logic [1:0] dbg_fsm
);

  localparam int KB = KEY_BITS / 8;
  localparam int NR = (KEY_BITS == 64) ? 12 : (KEY_BITS == 80) ? 16 : 20;
  localparam int HB = KEY_BITS / 2;
  localparam int CW = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  if (KEY_BITS != 64 && KEY_BITS != 80 && KEY_BITS != 96) begin : g_bad_key_bits
    $error("klein_serial: KEY_BITS must be 64, 80 or 96");
  end

  logic [1:0]          fsm_q, fsm_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       i_q, i_d;
  logic [63:0]         state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [63:0]         out_shift;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'h7;
      4'h1: sbox = 4'h4;
      4'h2: sbox = 4'hA;
      4'h3: sbox = 4'h9;
      4'h4: sbox = 4'h1;
      4'h5: sbox = 4'hF;
      4'h6: sbox = 4'hB;
      4'h7: sbox = 4'h0;
      4'h8: sbox = 4'hC;
      4'h9: sbox = 4'h3;
      4'hA: sbox = 4'h2;
      4'hB: sbox = 4'h6;
      4'hC: sbox = 4'h8;
      4'hD: sbox = 4'hE;
      4'hE: sbox = 4'hD;
      default: sbox = 4'h5;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // AES MixColumns on one 32-bit column, byte 0 in the MSBs.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    mix_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // AddRoundKey, SubNibbles, RotateNibbles (2 bytes left), MixNibbles.
  function automatic logic [63:0] klein_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] t, u, r;
    t = s ^ rk;
    for (int n = 0; n < 16; n++) begin
      u[4*n +: 4] = sbox(t[4*n +: 4]);
    end
    r = {u[47:0], u[63:48]};
    klein_round = {mix_col(r[63:32]), mix_col(r[31:0])};
  endfunction

  // One key-schedule step using round constant rc.
  function automatic logic [KEY_BITS-1:0] key_step(input logic [KEY_BITS-1:0] k,
                                                    input logic [7:0] rc);
    logic [HB-1:0] a, b, ar, br, na, nb;
    a  = k[KEY_BITS-1:HB];
    b  = k[HB-1:0];
    ar = {a[HB-9:0], a[HB-1:HB-8]};
    br = {b[HB-9:0], b[HB-1:HB-8]};
    na = br;
    nb = ar ^ br;
    na[HB-17 -: 8] = na[HB-17 -: 8] ^ rc;
    for (int n = 0; n < 4; n++) begin
      nb[HB-9-4*n -: 4] = sbox(nb[HB-9-4*n -: 4]);
    end
    key_step = {na, nb};
  endfunction

  // Next-state logic: byte loading, one round per cycle, final whitening, byte output.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    state_d = state_q;
    key_d   = key_q;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = {56'd0, inp};
          key_d   = {{(KEY_BITS-8){1'b0}}, key};
          cnt_d   = CW'(1);
          fsm_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        key_d = {key_q[KEY_BITS-9:0], key};
        // Only the first 8 bytes carry plaintext; later bytes are key-only.
        if (cnt_q < CW'(8)) begin
          state_d = {state_q[55:0], inp};
        end
        if (cnt_q == CW'(KB-1)) begin
          fsm_d = S_ROUND;
          cnt_d = '0;
          i_d   = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ROUND: begin
        // Rounds 1..NR run one per cycle; the cycle after round NR applies the
        // output whitening with the final key and hands over to OUT.
        if (i_q <= CW'(NR)) begin
          state_d = klein_round(state_q, key_q[KEY_BITS-1 -: 64]);
          key_d   = key_step(key_q, 8'(i_q));
          i_d     = i_q + CW'(1);
        end else begin
          state_d = state_q ^ key_q[KEY_BITS-1 -: 64];
          fsm_d   = S_OUT;
          cnt_d   = '0;
          i_d     = '0;
        end
      end
      S_OUT: begin
        if (cnt_q == CW'(7)) begin
          fsm_d = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        fsm_d = S_IDLE;
        cnt_d = '0;
        i_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      fsm_q   <= S_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  // Outputs decode directly from the registers so reset clears them at once.
  always_comb begin
    busy      = (fsm_q != S_IDLE);
    ready     = (fsm_q == S_OUT);
    out_shift = state_q << {cnt_q[2:0], 3'b000};
    out       = ready ? out_shift[63:56] : 8'h00;
    dbg_fsm   = fsm_q;
  end

endmodule

// File: tb/tb_klein_serial.sv
// tb_klein_serial: drives KLEIN-64, -80 and -96 instances side by side and checks
// them against a byte-array reference model of the cipher.
module tb_klein_serial;

  logic       ck = 1'b0;
  logic       rst;
  logic       start_s [3];
  logic [7:0] inp_s   [3];
  logic [7:0] key_s   [3];
  logic       busy_s  [3];
  logic       ready_s [3];
  logic [7:0] out_s   [3];
  logic [1:0] dbg_s   [3];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  localparam logic [3:0] SB [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                                     4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};
  localparam int MC [4] = '{2, 3, 1, 1};

  // Clock: 10 time-unit period.
  always #5 ck = ~ck;

  klein_serial #(.KEY_BITS(64)) u_k64 (
    .ck(ck), .rst(rst), .start(start_s[0]), .inp(inp_s[0]), .key(key_s[0]),
    .busy(busy_s[0]), .ready(ready_s[0]), .out(out_s[0]), .dbg_fsm(dbg_s[0]));
  klein_serial #(.KEY_BITS(80)) u_k80 (
    .ck(ck), .rst(rst), .start(start_s[1]), .inp(inp_s[1]), .key(key_s[1]),
    .busy(busy_s[1]), .ready(ready_s[1]), .out(out_s[1]), .dbg_fsm(dbg_s[1]));
  klein_serial #(.KEY_BITS(96)) u_k96 (
    .ck(ck), .rst(rst), .start(start_s[2]), .inp(inp_s[2]), .key(key_s[2]),
    .busy(busy_s[2]), .ready(ready_s[2]), .out(out_s[2]), .dbg_fsm(dbg_s[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 2; k++) begin
      if (m[k]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] v);
    return {SB[v[7:4]], SB[v[3:0]]};
  endfunction

  // Reference KLEIN on byte arrays; kb = key bytes (8, 10 or 12), key bytes taken from the top of kin.
  function automatic logic [63:0] ref_klein(input logic [63:0] pt, input logic [95:0] kin, input int kb);
    logic [7:0] s [8];
    logic [7:0] t [8];
    logic [7:0] k [12];
    logic [7:0] a [6];
    logic [7:0] b [6];
    logic [7:0] acc;
    logic [63:0] res;
    int h;
    int nr;
    h  = kb / 2;
    nr = 12 + 2 * (kb - 8);
    for (int j = 0; j < 8; j++) s[j] = pt[63-8*j -: 8];
    for (int j = 0; j < 12; j++) k[j] = (j < kb) ? kin[95-8*j -: 8] : 8'h00;
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 8; j++) s[j] = sub_byte(s[j] ^ k[j]);
      for (int j = 0; j < 8; j++) t[j] = s[(j+2)%8];
      for (int c = 0; c < 2; c++) begin
        for (int row = 0; row < 4; row++) begin
          acc = 8'h00;
          for (int col = 0; col < 4; col++) acc = acc ^ gmul(t[4*c+col], MC[(col-row+4)%4]);
          s[4*c+row] = acc;
        end
      end
      for (int j = 0; j < h; j++) begin
        a[j] = k[(j+1)%h];
        b[j] = k[h+(j+1)%h];
      end
      for (int j = 0; j < h; j++) begin
        k[j]   = b[j];
        k[h+j] = a[j] ^ b[j];
      end
      k[2]   = k[2] ^ 8'(r);
      k[h+1] = sub_byte(k[h+1]);
      k[h+2] = sub_byte(k[h+2]);
    end
    for (int j = 0; j < 8; j++) res[63-8*j -: 8] = s[j] ^ k[j];
    return res;
  endfunction

  // Driver: start edge carries byte 0, then one byte per cycle; start toggles randomly in LOAD.
  task automatic load_block(input int d, input logic [63:0] pt, input logic [95:0] kin);
    int kb;
    kb = 8 + 2 * d;
    @(negedge ck);
    start_s[d] = 1'b1;
    inp_s[d]   = pt[63:56];
    key_s[d]   = kin[95:88];
    for (int j = 1; j < kb; j++) begin
      @(negedge ck);
      start_s[d] = 1'($urandom_range(0, 1));
      inp_s[d]   = (j < 8) ? pt[63-8*j -: 8] : 8'($urandom);
      key_s[d]   = kin[95-8*j -: 8];
    end
  endtask

  // Runs one block and checks ready/busy/out every cycle; poke pulses start in ROUND and OUT.
  task automatic run_block(input int d, input logic [63:0] pt, input logic [95:0] kin,
                           input logic [63:0] exp, input bit poke, input string tag);
    int kb;
    int nr;
    int t0;
    logic exp_ready;
    logic [7:0] exp_byte;
    kb = 8 + 2 * d;
    nr = 12 + 4 * d;
    t0 = kb + nr;
    exp_q.delete();
    for (int j = 0; j < 8; j++) exp_q.push_back(exp[63-8*j -: 8]);
    load_block(d, pt, kin);
    for (int m = kb - 1; m <= t0 + 10; m++) begin
      @(negedge ck);
      exp_ready = (m >= t0) && (m <= t0 + 7);
      exp_byte  = 8'h00;
      if (exp_ready && exp_q.size() > 0) exp_byte = exp_q.pop_front();
      chk($sformatf("%s ready e%0d", tag, m), 64'(ready_s[d]), 64'(exp_ready));
      chk($sformatf("%s busy e%0d", tag, m), 64'(busy_s[d]), 64'(m <= t0 + 7));
      chk($sformatf("%s out e%0d", tag, m), 64'(out_s[d]), 64'(exp_byte));
      start_s[d] = poke && (m == kb + 3 || m == t0 + 2 || m == t0 + 7);
      inp_s[d]   = 8'($urandom);
    end
    chk($sformatf("%s bytes left", tag), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] pt;
    logic [95:0] kin;
    logic [63:0] exp;
    logic [7:0]  pc;
    logic [7:0]  kc;
    int p;
    int ph;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      inp_s[d]   = 8'h00;
      key_s[d]   = 8'h00;
    end

    // Reset: outputs must clear without any clock edge.
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset busy k%0d", d), 64'(busy_s[d]), 64'd0);
      chk($sformatf("reset ready k%0d", d), 64'(ready_s[d]), 64'd0);
      chk($sformatf("reset out k%0d", d), 64'(out_s[d]), 64'd0);
    end
    repeat (3) @(negedge ck);
    rst = 1'b1;

    // Reference model against the published vectors.
    chk("model k64", ref_klein({64{1'b1}}, 96'd0, 8), 64'hCDC0B51F14722BBE);
    chk("model k80", ref_klein({64{1'b1}}, 96'd0, 10), 64'h6677E20D1A53A431);
    chk("model k96", ref_klein({64{1'b1}}, 96'd0, 12), 64'hDB9FA7D33D8E8E36);

    // Known-answer vectors, all-zero key and all-ones plaintext.
    run_block(0, {64{1'b1}}, 96'd0, 64'hCDC0B51F14722BBE, 1'b0, "kat64");
    run_block(1, {64{1'b1}}, 96'd0, 64'h6677E20D1A53A431, 1'b0, "kat80");
    run_block(2, {64{1'b1}}, 96'd0, 64'hDB9FA7D33D8E8E36, 1'b0, "kat96");

    // Random plaintext and key against the reference model.
    for (int n = 0; n < 3; n++) begin
      for (int d = 0; d < 3; d++) begin
        pt  = {$urandom, $urandom};
        kin = {$urandom, $urandom, $urandom};
        run_block(d, pt, kin, ref_klein(pt, kin, 8 + 2 * d), 1'b0, $sformatf("rnd%0d k%0d", n, d));
      end
    end

    // start pulsed in ROUND, in OUT, and on the OUT->IDLE edge: one burst only.
    pt  = {$urandom, $urandom};
    kin = {$urandom, $urandom, $urandom};
    run_block(2, pt, kin, ref_klein(pt, kin, 12), 1'b1, "poke96");

    // Reset during round 5 of a KLEIN-80 block: immediate clear, no burst afterwards.
    pt  = {$urandom, $urandom};
    kin = {$urandom, $urandom, $urandom};
    load_block(1, pt, kin);
    repeat (5) @(negedge ck);
    start_s[1] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("abort busy", 64'(busy_s[1]), 64'd0);
    chk("abort ready", 64'(ready_s[1]), 64'd0);
    chk("abort out", 64'(out_s[1]), 64'd0);
    @(negedge ck);
    rst = 1'b1;
    for (int m = 0; m < 40; m++) begin
      @(negedge ck);
      chk($sformatf("post-abort ready c%0d", m), 64'(ready_s[1]), 64'd0);
      chk($sformatf("post-abort busy c%0d", m), 64'(busy_s[1]), 64'd0);
    end
    run_block(1, {64{1'b1}}, 96'd0, 64'h6677E20D1A53A431, 1'b0, "after-abort80");

    // start held high on KLEIN-64 with constant bytes: identical blocks, one IDLE cycle apart.
    pc  = 8'($urandom);
    kc  = 8'($urandom);
    pt  = {8{pc}};
    kin = {12{kc}};
    exp = ref_klein(pt, kin, 8);
    p   = 8 + 12 + 9;
    @(negedge ck);
    start_s[0] = 1'b1;
    inp_s[0]   = pc;
    key_s[0]   = kc;
    for (int m = 0; m < 3 * p; m++) begin
      @(negedge ck);
      ph = m % p;
      chk($sformatf("hold busy e%0d", m), 64'(busy_s[0]), 64'(ph != p - 1));
      chk($sformatf("hold ready e%0d", m), 64'(ready_s[0]), 64'(ph >= 20 && ph <= 27));
      if (ph >= 20 && ph <= 27) begin
        chk($sformatf("hold out e%0d", m), 64'(out_s[0]), 64'(exp[63-8*(ph-20) -: 8]));
      end else begin
        chk($sformatf("hold out e%0d", m), 64'(out_s[0]), 64'd0);
      end
    end
    start_s[0] = 1'b0;
    @(negedge ck);
    chk("hold release busy", 64'(busy_s[0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
